// File: rtl/toy_dispatch_xbar_buf_pkg.sv
// Shared dispatch types: issue-slot and EU-channel payloads, channel indices,
// and the conversion helpers used when an issue slot is pushed into a channel.
package toy_dispatch_xbar_buf_pkg;

  // Channel indices for the standard execution units
  localparam int EU_MEXT   = 0;
  localparam int EU_FLOAT  = 1;
  localparam int EU_CSR    = 2;
  localparam int EU_CUSTOM = 3;
  localparam int EU_CNT    = 4;

  // Payload held by an issue slot
  typedef struct packed {
    logic [5:0] inst_id;
    logic [5:0] phy_rd;
    logic [4:0] arch_rd;
    logic [7:0] opcode;
    logic [1:0] eu_sel;
  } issue_pkg;

  // Payload presented to an execution unit
  typedef struct packed {
    logic [5:0] inst_id;
    logic [5:0] inst_rd;
    logic [4:0] arch_reg_index;
    logic [7:0] opcode;
  } eu_pkg;

  // Rename slot fields into the EU view; the EU has no use for eu_sel
  function automatic eu_pkg issue2eu(input issue_pkg p);
    eu_pkg e;
    e.inst_id        = p.inst_id;
    e.inst_rd        = p.phy_rd;
    e.arch_reg_index = p.arch_rd;
    e.opcode         = p.opcode;
    return e;
  endfunction

  // One-hot channel mask derived from the slot's unit selector
  function automatic logic [EU_CNT-1:0] issue_goto_vec(input issue_pkg p);
    logic [EU_CNT-1:0] v;
    v = {EU_CNT{1'b0}};
    case (p.eu_sel)
      2'd0:    v[EU_MEXT]   = 1'b1;
      2'd1:    v[EU_FLOAT]  = 1'b1;
      2'd2:    v[EU_CSR]    = 1'b1;
      2'd3:    v[EU_CUSTOM] = 1'b1;
      default: v = {EU_CNT{1'b0}};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/toy_dispatch_eu_chan.sv
// One dispatch channel: round-robin pick among requesting issue slots,
// followed by a BUF_DEPTH-entry FIFO toward the execution unit.
module toy_dispatch_eu_chan
  import toy_dispatch_xbar_buf_pkg::*;
#(
  parameter int ISSUE_NUM = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [ISSUE_NUM-1:0]             req,
  input  issue_pkg                         pld [ISSUE_NUM],
  output logic [ISSUE_NUM-1:0]             grant,
  output logic                             eu_vld,
  output eu_pkg                            eu_pld,
  input  logic                             eu_rdy,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   eu_cnt
);

  localparam int PW = $clog2(ISSUE_NUM);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(ISSUE_NUM-1);

  logic [PW-1:0] rr_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  eu_pkg         mem_r [BUF_DEPTH];

  logic          win_found_s;
  logic [PW-1:0] win_idx_s;
  logic          push_s;
  logic          pop_s;

  // Round-robin search: first requester at or after rr_ptr, wrapping
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      if (!win_found_s && req[(int'(rr_ptr_r) + k) % ISSUE_NUM]) begin
        win_found_s = 1'b1;
        win_idx_s   = PW'((int'(rr_ptr_r) + k) % ISSUE_NUM);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Accept only with room left; a pop in the same cycle does not free a slot
  always_comb begin
    push_s = win_found_s && (cnt_r < FULL_CNT) && !flush && !rst;
    pop_s  = (cnt_r != CW'(0)) && eu_rdy;
    grant  = '0;
    if (push_s) begin
      grant[win_idx_s] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Pointer, occupancy and round-robin state
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
        rr_ptr_r <= (win_idx_s == LAST_SLOT) ? PW'(0) : win_idx_s + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // FIFO storage; written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= issue2eu(pld[win_idx_s]);
    end
  end

  // Head presentation; empty channel shows an all-zero payload
  always_comb begin
    eu_vld = (cnt_r != CW'(0));
    eu_cnt = cnt_r;
    if (eu_vld) begin
      eu_pld = mem_r[rd_ptr_r];
    end else begin
      eu_pld = '0;
    end
  end

endmodule

// File: rtl/toy_dispatch_xbar_buf.sv
// Dispatch crossbar: masks slot requests per channel (lowest channel wins on
// a multi-hot target), runs one buffered channel per EU and merges grants.
module toy_dispatch_xbar_buf
  import toy_dispatch_xbar_buf_pkg::*;
#(
  parameter int ISSUE_NUM = 8,
  parameter int EU_NUM    = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic [ISSUE_NUM-1:0]                          v_issue_en,
  input  issue_pkg                                      v_issue_pld [ISSUE_NUM],
  input  logic [EU_NUM-1:0][ISSUE_NUM-1:0]              v_issue_goto,
  output logic [ISSUE_NUM-1:0]                          v_issue_rdy,
  output logic [EU_NUM-1:0]                             v_eu_vld,
  output eu_pkg                                         v_eu_pld [EU_NUM],
  input  logic [EU_NUM-1:0]                             v_eu_rdy,
  output logic [EU_NUM-1:0][$clog2(BUF_DEPTH+1)-1:0]    v_eu_cnt
);

  logic [EU_NUM-1:0][ISSUE_NUM-1:0] req_s;
  logic [EU_NUM-1:0][ISSUE_NUM-1:0] grant_s;
  logic [ISSUE_NUM-1:0]             taken_s;

  // Route each valid slot to its lowest targeted channel only
  always_comb begin
    req_s   = '0;
    taken_s = '0;
    for (int e = 0; e < EU_NUM; e++) begin
      for (int i = 0; i < ISSUE_NUM; i++) begin
        if (v_issue_en[i] && v_issue_goto[e][i] && !taken_s[i]) begin
          req_s[e][i] = 1'b1;
          taken_s[i]  = 1'b1;
        end else begin
          req_s[e][i] = 1'b0;
        end
      end
    end
  end

  for (genvar e = 0; e < EU_NUM; e++) begin : g_chan
    toy_dispatch_eu_chan #(
      .ISSUE_NUM (ISSUE_NUM),
      .BUF_DEPTH (BUF_DEPTH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .req    (req_s[e]),
      .pld    (v_issue_pld),
      .grant  (grant_s[e]),
      .eu_vld (v_eu_vld[e]),
      .eu_pld (v_eu_pld[e]),
      .eu_rdy (v_eu_rdy[e]),
      .eu_cnt (v_eu_cnt[e])
    );
  end

  // A slot is accepted when any channel granted it
  always_comb begin
    v_issue_rdy = '0;
    for (int e = 0; e < EU_NUM; e++) begin
      v_issue_rdy = v_issue_rdy | grant_s[e];
    end
  end

endmodule

// File: tb/tb_toy_dispatch_xbar_buf.sv
// Directed bench for toy_dispatch_xbar_buf with hand-computed expectations.
module tb_toy_dispatch_xbar_buf;
  import toy_dispatch_xbar_buf_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [7:0]      en;
  issue_pkg        pld [8];
  logic [3:0][7:0] gt;
  logic [7:0]      rdy;
  logic [3:0]      eu_vld;
  eu_pkg           eu_pld [4];
  logic [3:0]      eu_rdy;
  logic [3:0][1:0] cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hot_cnt;

  toy_dispatch_xbar_buf #(.ISSUE_NUM(8), .EU_NUM(4), .BUF_DEPTH(2)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .v_issue_en   (en),
    .v_issue_pld  (pld),
    .v_issue_goto (gt),
    .v_issue_rdy  (rdy),
    .v_eu_vld     (eu_vld),
    .v_eu_pld     (eu_pld),
    .v_eu_rdy     (eu_rdy),
    .v_eu_cnt     (cnt)
  );

  always #5 clk = ~clk;

  // Protocol guard: a valid slot may target at most one channel
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      hot_cnt = 0;
      for (int e = 0; e < 4; e++) hot_cnt += int'(gt[e][i]);
      if (en[i] && hot_cnt > 1) $error("illegal multi-hot goto on slot %0d", i);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic issue_pkg mk(input int slot, input int chan);
    issue_pkg p;
    logic [5:0] id;
    id        = 6'(chan * 8 + slot);
    p.inst_id = id;
    p.phy_rd  = id ^ 6'h2A;
    p.arch_rd = 5'(id + 6'd3);
    p.opcode  = 8'h40 + 8'(id);
    p.eu_sel  = 2'(chan);
    return p;
  endfunction

  function automatic eu_pkg ex(input int slot, input int chan);
    eu_pkg e;
    logic [5:0] id;
    id               = 6'(chan * 8 + slot);
    e.inst_id        = id;
    e.inst_rd        = id ^ 6'h2A;
    e.arch_reg_index = 5'(id + 6'd3);
    e.opcode         = 8'h40 + 8'(id);
    return e;
  endfunction

  task automatic drive(input int slot, input int chan);
    logic [3:0] gv;
    en[slot]  = 1'b1;
    pld[slot] = mk(slot, chan);
    gv        = issue_goto_vec(pld[slot]);
    for (int e = 0; e < 4; e++) gt[e][slot] = gv[e];
  endtask

  task automatic drop(input int slot);
    en[slot] = 1'b0;
    for (int e = 0; e < 4; e++) gt[e][slot] = 1'b0;
  endtask

  initial begin
    logic [7:0] rr_exp [6];
    int         rr_slot [6];
    rr_exp  = '{8'h02, 8'h10, 8'h40, 8'h02, 8'h10, 8'h40};
    rr_slot = '{1, 4, 6, 1, 4, 6};

    rst    = 1'b1;
    flush  = 1'b0;
    en     = 8'h00;
    gt     = '0;
    eu_rdy = 4'h0;
    for (int i = 0; i < 8; i++) pld[i] = '0;

    // Reset state, with a request pending that must not be accepted
    drive(0, EU_MEXT);
    tick();
    tick();
    chk("rst_rdy", 64'(rdy), 64'h00);
    chk("rst_vld", 64'(eu_vld), 64'h0);
    chk("rst_cnt", 64'(cnt), 64'h00);
    chk("rst_pld0", 64'(eu_pld[0]), 64'h0);
    drop(0);
    rst = 1'b0;

    // 1. Single issue slot3 -> mext
    tick();
    drive(3, EU_MEXT);
    eu_rdy = 4'hF;
    #1;
    chk("t1_rdy_c0", 64'(rdy), 64'h08);
    tick();
    drop(3);
    #1;
    chk("t1_vld_c1", 64'(eu_vld), 64'h1);
    chk("t1_pld_c1", 64'(eu_pld[0]), 64'(ex(3, EU_MEXT)));
    chk("t1_cnt_c1", 64'(cnt[0]), 64'd1);
    chk("t1_rdy_c1", 64'(rdy), 64'h00);
    tick();
    chk("t1_cnt_c2", 64'(cnt[0]), 64'd0);
    chk("t1_vld_c2", 64'(eu_vld), 64'h0);
    chk("t1_pld_c2", 64'(eu_pld[0]), 64'h0);

    // 2. Round-robin fairness on float among slots 1,4,6
    tick();
    drive(1, EU_FLOAT);
    drive(4, EU_FLOAT);
    drive(6, EU_FLOAT);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t2_rdy_%0d", k), 64'(rdy), 64'(rr_exp[k]));
      if (k > 0) chk($sformatf("t2_head_%0d", k), 64'(eu_pld[1]), 64'(ex(rr_slot[k-1], EU_FLOAT)));
      tick();
    end
    drop(1);
    drop(4);
    drop(6);
    #1;
    chk("t2_head_last", 64'(eu_pld[1]), 64'(ex(6, EU_FLOAT)));
    chk("t2_cnt", 64'(cnt[1]), 64'd1);
    tick();

    // 4. Concurrent channels
    drive(0, EU_MEXT);
    drive(1, EU_FLOAT);
    drive(2, EU_CSR);
    drive(3, EU_CUSTOM);
    #1;
    chk("t4_rdy", 64'(rdy), 64'h0F);
    tick();
    for (int s = 0; s < 4; s++) drop(s);
    #1;
    chk("t4_vld", 64'(eu_vld), 64'hF);
    for (int e = 0; e < 4; e++) chk($sformatf("t4_pld_%0d", e), 64'(eu_pld[e]), 64'(ex(e, e)));
    tick();

    // 3. Backpressure on csr: slots 2 and 5, csr pointer now at 3
    eu_rdy = 4'b1011;
    drive(2, EU_CSR);
    drive(5, EU_CSR);
    #1;
    chk("t3_rdy_c0", 64'(rdy), 64'h20);
    chk("t3_cnt_c0", 64'(cnt[2]), 64'd0);
    tick();
    chk("t3_rdy_c1", 64'(rdy), 64'h04);
    chk("t3_cnt_c1", 64'(cnt[2]), 64'd1);
    chk("t3_head_c1", 64'(eu_pld[2]), 64'(ex(5, EU_CSR)));
    tick();
    chk("t3_rdy_full", 64'(rdy), 64'h00);
    chk("t3_cnt_full", 64'(cnt[2]), 64'd2);
    tick();
    eu_rdy[2] = 1'b1;
    #1;
    chk("t3_rdy_popcyc", 64'(rdy), 64'h00);
    chk("t3_head_popcyc", 64'(eu_pld[2]), 64'(ex(5, EU_CSR)));
    tick();
    eu_rdy[2] = 1'b0;
    #1;
    chk("t3_cnt_after_pop", 64'(cnt[2]), 64'd1);
    chk("t3_head_after_pop", 64'(eu_pld[2]), 64'(ex(2, EU_CSR)));
    chk("t3_rdy_regrant", 64'(rdy), 64'h20);
    tick();
    chk("t3_cnt_refull", 64'(cnt[2]), 64'd2);
    chk("t3_rdy_refull", 64'(rdy), 64'h00);

    // Fill mext too (csr stays full with requests pending)
    eu_rdy = 4'b1010;
    drive(6, EU_MEXT);
    #1;
    chk("t5_fill_c0", 64'(rdy), 64'h40);
    tick();
    chk("t5_fill_c1", 64'(rdy), 64'h40);
    tick();
    chk("t5_fill_cnt", 64'(cnt), 64'(8'b00_10_00_10));
    chk("t5_fill_rdy", 64'(rdy), 64'h00);

    // 5. Flush with requests pending (float has room) and pops requested
    drive(4, EU_FLOAT);
    eu_rdy = 4'hF;
    flush  = 1'b1;
    #1;
    chk("t5_flush_rdy", 64'(rdy), 64'h00);
    tick();
    flush = 1'b0;
    drop(2);
    drop(4);
    drop(5);
    drop(6);
    #1;
    chk("t5_vld", 64'(eu_vld), 64'h0);
    chk("t5_cnt", 64'(cnt), 64'h00);
    chk("t5_pld0", 64'(eu_pld[0]), 64'h0);
    chk("t5_pld2", 64'(eu_pld[2]), 64'h0);
    drive(3, EU_FLOAT);
    drive(7, EU_FLOAT);
    #1;
    chk("t5_rr_held", 64'(rdy), 64'h08);
    tick();
    drop(3);
    drop(7);
    #1;
    chk("t5_post_head", 64'(eu_pld[1]), 64'(ex(3, EU_FLOAT)));
    chk("t5_post_cnt", 64'(cnt[1]), 64'd1);
    tick();

    // 6. Reset mid-operation with full mext and csr FIFOs
    eu_rdy = 4'h0;
    drive(0, EU_MEXT);
    drive(4, EU_CSR);
    #1;
    chk("t6_fill_c0", 64'(rdy), 64'h11);
    tick();
    chk("t6_fill_c1", 64'(rdy), 64'h11);
    tick();
    chk("t6_full_cnt", 64'(cnt), 64'(8'b00_10_00_10));
    rst    = 1'b1;
    eu_rdy = 4'hF;
    #1;
    chk("t6_rst_rdy", 64'(rdy), 64'h00);
    tick();
    rst = 1'b0;
    drop(0);
    drop(4);
    #1;
    chk("t6_vld", 64'(eu_vld), 64'h0);
    chk("t6_cnt", 64'(cnt), 64'h00);
    chk("t6_pld0", 64'(eu_pld[0]), 64'h0);
    chk("t6_pld2", 64'(eu_pld[2]), 64'h0);
    drive(0, EU_MEXT);
    drive(5, EU_MEXT);
    #1;
    chk("t6_first_grant", 64'(rdy), 64'h01);
    tick();
    drop(0);
    drop(5);
    #1;
    chk("t6_head", 64'(eu_pld[0]), 64'(ex(0, EU_MEXT)));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
